// File: rtl/wb_mtimer_if.sv
// rtl/wb_mtimer_if.sv - pipelined Wishbone bus bundle for the machine timer
//   master: drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel
//   slave : drives wb_stall, wb_ack, wb_err, wb_dat_r
interface wb_mtimer_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_stall;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_dat_r;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_stall, wb_ack, wb_err, wb_dat_r
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_stall, wb_ack, wb_err, wb_dat_r
  );
endinterface

// File: rtl/wb_mtimer.sv
// rtl/wb_mtimer.sv - memory-mapped mtime/mtimecmp/msip block on a Wishbone slave
//   clk_i   : system clock
//   reset_i : synchronous active-low reset
//   wb      : Wishbone slave (single-cycle registered ack/err, stall tied low)
//   mtip_o  : timer interrupt pending (registered mtime >= mtimecmp)
//   msip_o  : software interrupt pending (msip register bit)
module wb_mtimer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  wb_mtimer_if.slave    wb,
  output logic          mtip_o,
  output logic          msip_o
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [15:0] div_q, div_d;
  logic        mtip_q;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic        req, hit, bad, wr, wr_time, tick;
  logic [4:0]  off;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = sel[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    req   = wb.wb_cyc & wb.wb_stb;
    hit   = (wb.wb_adr[31:5] == BASE_ADDR[31:5]);
    off   = wb.wb_adr[4:0];
    // Unmapped tail of the window and misaligned word accesses are errors.
    bad   = (off >= 5'h14) | (off[1:0] != 2'b00);
    ack_d = req & hit & ~bad;
    err_d = req & hit & bad;
    wr    = ack_d & wb.wb_we;
    tick  = (div_q == DIV_LAST);
    // An all-lanes-off write is a pure no-op, so it must not disturb the divider.
    wr_time = wr & (wb.wb_sel != 4'h0) & ((off == 5'h0C) | (off == 5'h10));

    dat_d = 32'h0;
    if (ack_d) begin
      case (off)
        5'h00:   dat_d = {31'h0, msip_q};
        5'h04:   dat_d = mtimecmp_q[31:0];
        5'h08:   dat_d = mtimecmp_q[63:32];
        5'h0C:   dat_d = mtime_q[31:0];
        5'h10:   dat_d = mtime_q[63:32];
        default: dat_d = 32'h0;
      endcase
    end

    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    if (wr) begin
      case (off)
        5'h00:   if (wb.wb_sel[0]) msip_d = wb.wb_dat_w[0];
        5'h04:   mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], wb.wb_dat_w, wb.wb_sel);
        5'h08:   mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], wb.wb_dat_w, wb.wb_sel);
        default: ;
      endcase
    end

    // A software write to mtime wins over the tick and restarts the divider;
    // the other half is left alone (no carry).
    mtime_d = mtime_q;
    div_d   = div_q;
    if (wr_time) begin
      div_d = 16'h0;
      if (off == 5'h0C) mtime_d[31:0]  = lane_merge(mtime_q[31:0], wb.wb_dat_w, wb.wb_sel);
      else              mtime_d[63:32] = lane_merge(mtime_q[63:32], wb.wb_dat_w, wb.wb_sel);
    end else if (tick) begin
      div_d   = 16'h0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      div_d = div_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      div_q      <= 16'h0;
      mtip_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'h0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      div_q      <= div_d;
      // Compare on the present register values, so mtip lags by one cycle.
      mtip_q     <= (mtime_q >= mtimecmp_q);
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign wb.wb_stall = 1'b0;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign wb.wb_dat_r = dat_q;
  assign mtip_o      = mtip_q;
  assign msip_o      = msip_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// tb/tb_wb_mtimer.sv - scoreboard bench for wb_mtimer (TICK_DIV=1 and TICK_DIV=4 instances)
module tb_wb_mtimer;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mtip_a, msip_a, mtip_b, msip_b;

  wb_mtimer_if bus_a();
  wb_mtimer_if bus_b();

  wb_mtimer #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_a (
    .clk_i(clk), .reset_i(rst_n), .wb(bus_a), .mtip_o(mtip_a), .msip_o(msip_a)
  );
  wb_mtimer #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_b (
    .clk_i(clk), .reset_i(rst_n), .wb(bus_b), .mtip_o(mtip_b), .msip_o(msip_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  // Reference state for instance A; entries are {err, ack, data}.
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_mtip;
  bit          armed = 0;
  logic [33:0] qa[$];
  // Reference state for instance B (read-only use).
  logic [63:0] b_time;
  int          b_div;
  logic [31:0] qb[$];

  always @(posedge clk) begin : model_a
    logic [4:0]  off;
    logic [31:0] rd, wd;
    logic [3:0]  s;
    bit          mt_wr;
    logic        nxt_mtip;
    if (!rst_n) begin
      armed  = 1;
      m_time = 64'h0;
      m_cmp  = '1;
      m_msip = 1'b0;
      m_mtip = 1'b0;
      qa.delete();
    end else begin
      nxt_mtip = (m_time >= m_cmp);
      mt_wr = 0;
      if (bus_a.wb_cyc && bus_a.wb_stb && bus_a.wb_adr[31:5] == BASE[31:5]) begin
        off = bus_a.wb_adr[4:0];
        if (off > 5'h13 || off[1:0] != 2'b00) begin
          qa.push_back({2'b10, 32'h0});
        end else begin
          case (off)
            5'h00:   rd = {31'h0, m_msip};
            5'h04:   rd = m_cmp[31:0];
            5'h08:   rd = m_cmp[63:32];
            5'h0C:   rd = m_time[31:0];
            default: rd = m_time[63:32];
          endcase
          qa.push_back({2'b01, rd});
          if (bus_a.wb_we) begin
            wd = bus_a.wb_dat_w;
            s  = bus_a.wb_sel;
            case (off)
              5'h00: if (s[0]) m_msip = wd[0];
              5'h04: m_cmp[31:0]  = merge_ref(m_cmp[31:0], wd, s);
              5'h08: m_cmp[63:32] = merge_ref(m_cmp[63:32], wd, s);
              5'h0C: begin m_time[31:0]  = merge_ref(m_time[31:0], wd, s);  mt_wr = (s != 0); end
              default: begin m_time[63:32] = merge_ref(m_time[63:32], wd, s); mt_wr = (s != 0); end
            endcase
          end
        end
      end
      if (!mt_wr) m_time = m_time + 64'd1;
      m_mtip = nxt_mtip;
    end
  end

  always @(posedge clk) begin : model_b
    if (!rst_n) begin
      b_time = 64'h0;
      b_div  = 0;
      qb.delete();
    end else begin
      if (bus_b.wb_cyc && bus_b.wb_stb && bus_b.wb_adr == BASE + 32'h0C) qb.push_back(b_time[31:0]);
      if (b_div == 3) begin b_div = 0; b_time = b_time + 64'd1; end
      else b_div = b_div + 1;
    end
  end

  always @(negedge clk) begin : mon
    logic [33:0] ea;
    logic [31:0] eb;
    if (armed) begin
      check_eq("a_mtip", {63'h0, mtip_a}, {63'h0, m_mtip});
      check_eq("a_msip", {63'h0, msip_a}, {63'h0, m_msip});
      check_eq("a_stall", {63'h0, bus_a.wb_stall}, 64'h0);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check_eq("a_ack", {63'h0, bus_a.wb_ack}, {63'h0, ea[32]});
        check_eq("a_err", {63'h0, bus_a.wb_err}, {63'h0, ea[33]});
        check_eq("a_dat", {32'h0, bus_a.wb_dat_r}, {32'h0, ea[31:0]});
      end else begin
        check_eq("a_idle", {61'h0, bus_a.wb_ack, bus_a.wb_err, |bus_a.wb_dat_r}, 64'h0);
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check_eq("b_ack", {63'h0, bus_b.wb_ack}, 64'h1);
        check_eq("b_dat", {32'h0, bus_b.wb_dat_r}, {32'h0, eb});
      end else begin
        check_eq("b_idle", {62'h0, bus_b.wb_ack, bus_b.wb_err}, 64'h0);
      end
      check_eq("b_irq", {62'h0, mtip_b, msip_b}, 64'h0);
    end
  end

  task automatic txa(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    bus_a.wb_cyc = 1'b1; bus_a.wb_stb = 1'b1; bus_a.wb_we = we;
    bus_a.wb_adr = adr;  bus_a.wb_dat_w = dat; bus_a.wb_sel = sel;
    @(negedge clk);
  endtask

  task automatic idle_a(input int n);
    bus_a.wb_cyc = 1'b0; bus_a.wb_stb = 1'b0; bus_a.wb_we = 1'b0;
    bus_a.wb_adr = 32'h0; bus_a.wb_dat_w = 32'h0; bus_a.wb_sel = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus_b.wb_cyc = 1'b0; bus_b.wb_stb = 1'b0; bus_b.wb_we = 1'b0;
    bus_b.wb_adr = 32'h0; bus_b.wb_dat_w = 32'h0; bus_b.wb_sel = 4'h0;
    idle_a(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (38) @(negedge clk);

    // TICK_DIV=4 instance: mtime_lo read back-to-back over one divider period.
    for (int i = 0; i < 5; i++) begin
      bus_b.wb_cyc = 1'b1; bus_b.wb_stb = 1'b1; bus_b.wb_adr = BASE + 32'h0C;
      @(negedge clk);
    end
    bus_b.wb_cyc = 1'b0; bus_b.wb_stb = 1'b0;

    // Reset-value reads (mtime has been running since reset).
    txa(0, BASE + 32'h0C, 0, 4'h0);
    txa(0, BASE + 32'h08, 0, 4'h0);
    idle_a(2);

    // Restart mtime, arm compare at 0x20 and watch mtip rise, then push it away.
    txa(1, BASE + 32'h10, 32'h0, 4'hF);
    txa(1, BASE + 32'h0C, 32'h0, 4'hF);
    txa(1, BASE + 32'h08, 32'h0, 4'hF);
    txa(1, BASE + 32'h04, 32'h20, 4'hF);
    idle_a(40);
    txa(1, BASE + 32'h08, 32'h1, 4'hF);
    idle_a(3);

    // 64-bit wrap with mtimecmp = 0.
    txa(1, BASE + 32'h08, 32'h0, 4'hF);
    txa(1, BASE + 32'h04, 32'h0, 4'hF);
    txa(1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    txa(1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    idle_a(1);
    txa(0, BASE + 32'h0C, 0, 4'h0);
    txa(0, BASE + 32'h10, 0, 4'h0);
    idle_a(3);

    // msip lane handling and partial byte merge.
    txa(1, BASE + 32'h00, 32'hFFFF_FFFF, 4'b0001);
    txa(0, BASE + 32'h00, 0, 4'h0);
    txa(1, BASE + 32'h00, 32'h0, 4'b0010);
    txa(0, BASE + 32'h00, 0, 4'h0);
    txa(1, BASE + 32'h04, 32'hDEAD_BEEF, 4'h0);
    txa(1, BASE + 32'h08, 32'hA5C3_1234, 4'b0101);
    txa(0, BASE + 32'h04, 0, 4'h0);
    txa(0, BASE + 32'h08, 0, 4'h0);
    idle_a(2);

    // Errors, misses and ignored strobes.
    txa(0, BASE + 32'h14, 0, 4'h0);
    txa(1, BASE + 32'h06, 32'h1234_5678, 4'hF);
    txa(0, BASE + 32'h04, 0, 4'h0);
    txa(0, BASE + 32'h1C, 0, 4'h0);
    txa(0, BASE + 32'h20, 0, 4'h0);
    txa(1, 32'h5000_0004, 32'h7, 4'hF);
    bus_a.wb_cyc = 1'b0; bus_a.wb_stb = 1'b1; bus_a.wb_adr = BASE + 32'h0C;
    @(negedge clk);
    txa(0, BASE + 32'h04, 0, 4'h0);
    idle_a(2);

    // Strobe presented while reset is asserted must not be answered.
    txa(1, BASE + 32'h00, 32'h1, 4'hF);
    bus_a.wb_we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    idle_a(1);
    rst_n = 1'b1;
    txa(0, BASE + 32'h08, 0, 4'h0);
    txa(0, BASE + 32'h00, 0, 4'h0);
    idle_a(3);

    check_eq("q_drain", 64'(qa.size() + qb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
